// File: rtl/aes_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_pkg : shared AES-128 types, constants and byte/word helpers       |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int AES_NK = 4;

   typedef logic [127:0] key128_t;
   typedef logic [31:0]  word_t;
   typedef logic [7:0]   byte_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   function automatic byte_t xtime(input byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gf_mul(input byte_t a, input byte_t b);
      byte_t p;
      byte_t aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box built from the GF(2^8) inverse (a^254, which maps 0 to 0) and the affine map
   function automatic byte_t sbox(input byte_t a);
      byte_t inv;
      inv = a;
      for (int i = 0; i < 6; i++) inv = gf_mul(gf_mul(inv, inv), a);
      inv = gf_mul(inv, inv);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_sched_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_key_sched_if : control and round-key read bus of aes_key_sched    |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
interface aes_key_sched_if;
   import aes_pkg::*;

   logic       start;
   key128_t    key_in;
   logic [3:0] rk_addr;
   key128_t    rk_data;
   logic       busy;
   logic       done;
   logic       keys_valid;

   modport master (
      output start, key_in, rk_addr,
      input  rk_data, busy, done, keys_valid
   );

   modport slave (
      input  start, key_in, rk_addr,
      output rk_data, busy, done, keys_valid
   );

endinterface
`default_nettype wire

// File: rtl/aes_key_round.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_key_round : combinational AES-128 single-round key expansion      |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module aes_key_round
   import aes_pkg::*;
(
   input  key128_t prev_key,
   input  word_t   rcon_word,
   output key128_t next_key
);

   word_t       w_rot;
   wire  [31:0] w_sub;
   word_t       w_temp;
   word_t       w_n0, w_n1, w_n2, w_n3;

   assign w_rot = rot_word(prev_key[31:0]);

   generate
      for (genvar gi = 0; gi < AES_NK; gi++) begin : g_sbox
         assign w_sub[gi*8 +: 8] = sbox(w_rot[gi*8 +: 8]);
      end
   endgenerate

   assign w_temp = w_sub ^ rcon_word;
   assign w_n0   = prev_key[127:96] ^ w_temp;
   assign w_n1   = prev_key[95:64]  ^ w_n0;
   assign w_n2   = prev_key[63:32]  ^ w_n1;
   assign w_n3   = prev_key[31:0]   ^ w_n2;

   assign next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_key_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_key_sched : iterative AES-128 key schedule, one round per cycle,  |
// |                 11 round keys stored for random-access read           |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module aes_key_sched
   import aes_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   aes_key_sched_if.slave  bus
);

   localparam logic [3:0] c_last_round = 4'(AES_NR);

   state_t     r_state, w_next_state;
   logic [3:0] r_round;
   byte_t      r_rcon;
   logic       r_keys_valid;
   key128_t    r_slots [0:AES_NR];

   logic       w_accept;
   logic [3:0] w_prev_idx;
   key128_t    w_prev_key;
   key128_t    w_next_key;

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_next_state = ST_RUN;
               w_accept     = 1'b1;
            end
         end
         ST_RUN:  if (r_round == c_last_round) w_next_state = ST_FIN;
         ST_FIN:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Counter value 0 only occurs outside RUN; guard keeps the read in range
   assign w_prev_idx = r_round - 4'd1;
   assign w_prev_key = (w_prev_idx <= c_last_round) ? r_slots[w_prev_idx] : '0;

   aes_key_round u_round (
      .prev_key  (w_prev_key),
      .rcon_word ({r_rcon, 24'h0}),
      .next_key  (w_next_key)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_round      <= '0;
         r_rcon       <= 8'h01;
         r_keys_valid <= 1'b0;
         for (int i = 0; i <= AES_NR; i++) r_slots[i] <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_slots[0]   <= bus.key_in;
            r_round      <= 4'd1;
            r_rcon       <= 8'h01;
            r_keys_valid <= 1'b0;
         end else if (r_state == ST_RUN) begin
            r_slots[r_round] <= w_next_key;
            r_round          <= r_round + 4'd1;
            r_rcon           <= xtime(r_rcon);
            if (r_round == c_last_round) r_keys_valid <= 1'b1;
         end
      end
   end

   assign bus.busy       = (r_state == ST_RUN);
   assign bus.done       = (r_state == ST_FIN);
   assign bus.keys_valid = r_keys_valid;
   assign bus.rk_data    = (bus.rk_addr <= c_last_round) ? r_slots[bus.rk_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_aes_key_sched : FIPS-197 vector bench with expected-key scoreboard |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module tb_aes_key_sched;
   import aes_pkg::*;

   typedef struct {
      key128_t key;
      key128_t s1;
      key128_t s10;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   vec_t sb_q[$];
   vec_t vecs[2];

   aes_key_sched_if bus();

   aes_key_sched u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic read_chk(input string name, input logic [3:0] a, input key128_t exp);
      bus.rk_addr = a;
      #1;
      chk(name, bus.rk_data, exp);
   endtask

   task automatic launch(input vec_t v, input bit push);
      @(negedge clk);
      bus.key_in = v.key;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("busy_after_accept", bus.busy, 1);
      chk("kv_clear_after_accept", bus.keys_valid, 0);
      if (push) sb_q.push_back(v);
   endtask

   task automatic score_slots();
      vec_t v;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
         v = sb_q.pop_front();
         read_chk("slot0", 4'd0, v.key);
         read_chk("slot1", 4'd1, v.s1);
         read_chk("slot10", 4'd10, v.s10);
      end
   endtask

   task automatic wait_done_and_score();
      int cyc = 0;
      while (bus.done !== 1'b1 && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("done_latency", cyc, 10);
      chk("busy_in_fin", bus.busy, 0);
      chk("kv_in_fin", bus.keys_valid, 1);
      score_slots();
      @(posedge clk);
      #1;
      chk("done_low_in_idle", bus.done, 0);
   endtask

   initial begin
      int   d0;
      int   cyc;
      vec_t v_other;

      vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  s1:  128'ha0fafe1788542cb123a339392a6c7605,
                  s10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{key: 128'h0,
                  s1:  128'h62636363626363636263636362636363,
                  s10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      v_other = '{key: 128'hdeadbeef0123456789abcdeffedcba98, s1: '0, s10: '0};

      bus.start   = 1'b0;
      bus.key_in  = '0;
      bus.rk_addr = '0;
      rst_n       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_kv", bus.keys_valid, 0);
      for (int a = 0; a <= 10; a++) read_chk("reset_slot", 4'(a), '0);
      rst_n = 1'b1;

      // Second vector runs straight after the first: also the restart case
      for (int i = 0; i < 2; i++) begin
         launch(vecs[i], 1'b1);
         wait_done_and_score();
      end

      chk("kv_before_oor", bus.keys_valid, 1);
      read_chk("oor_11", 4'd11, '0);
      read_chk("oor_15", 4'd15, '0);

      // start with a foreign key at T+3 (RUN) and T+11 sample (FIN) must be ignored
      d0 = done_cnt;
      launch(vecs[0], 1'b1);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 20) begin
         if (cyc == 2) begin
            bus.key_in = v_other.key;
            bus.start  = 1'b1;
         end else begin
            bus.start  = 1'b0;
         end
         if (cyc == 9) chk("busy_at_t9", bus.busy, 1);
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("ignore_latency", cyc, 10);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("fin_start_ignored_busy", bus.busy, 0);
      chk("fin_start_ignored_done", bus.done, 0);
      score_slots();
      repeat (3) @(posedge clk);
      #1;
      chk("single_done_pulse", done_cnt - d0, 1);
      chk("idle_after_ignore", bus.busy, 0);

      // Reset at T+5 aborts the run
      d0 = done_cnt;
      launch(vecs[0], 1'b0);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_kv", bus.keys_valid, 0);
      for (int a = 0; a <= 10; a++) read_chk("abort_slot", 4'(a), '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_idle_busy", bus.busy, 0);

      // start on the first edge after reset release is accepted
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n      = 1'b1;
      bus.key_in = vecs[1].key;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("start_after_reset_busy", bus.busy, 1);
      sb_q.push_back(vecs[1]);
      wait_done_and_score();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-low reset; reset is sampled only on the rising clock edge.
REQ-002 Port `clk`, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-003 Port `rst_n`, input, 1 bit: synchronous active-low reset.
REQ-004 Port `start`, input, 1 bit: request to expand `key_in`; sampled only while idle.
REQ-005 Port `key_in`, input, 128 bits: AES-128 cipher key, word 0 in bits [127:96].
REQ-006 Port `rk_addr`, input, 4 bits: round-key read index, valid range 0..10.
REQ-007 Port `rk_data`, output, 128 bits: round key at `rk_addr`, combinational read.
REQ-008 Port `busy`, output, 1 bit: expansion in progress.
REQ-009 Port `done`, output, 1 bit: single-cycle pulse when round key 10 has been written.
REQ-010 Port `keys_valid`, output, 1 bit: all 11 round keys are stored and stable.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN, FIN.
- IDLE -> RUN when `start` is 1.
- RUN -> FIN after round 10 is written.
- FIN -> IDLE unconditionally.
REQ-012 On the edge where `start` is accepted (edge T), the block SHALL:
- write `key_in` to round-key slot 0;
- set the round counter to 1 and rcon to 8'h01;
- clear `keys_valid`;
- set `busy` to 1.
REQ-013 In RUN, each edge SHALL compute slot[r] from slot[r-1] and {rcon, 24'h0}, using the standard FIPS-197 expansion (RotWord, SubWord, rcon XOR, word chaining). After each edge, r increments and rcon is replaced by xtime(rcon).
REQ-014 Rounds 1..10 SHALL be written on edges T+1..T+10, one round per cycle.
REQ-015 The rcon sequence SHALL be 01,02,04,08,10,20,40,80,1B,36; xtime wraps from 80 to 1B by reduction with 8'h1B.
REQ-016 After edge T+10, the block SHALL be in FIN with `done`=1, `busy`=0 and `keys_valid`=1. After edge T+11, it is back in IDLE with `done`=0.
REQ-017 `busy` SHALL be 1 from edge T through edge T+9 inclusive, that is, during RUN.
REQ-018 `start` SHALL be ignored in RUN and FIN. Stored keys and progress are unaffected.
REQ-019 `start` held high in IDLE SHALL restart expansion, each time overwriting slot 0 from the current `key_in`.
REQ-020 `rk_data` SHALL return slot[`rk_addr`] for addresses 0..10 and 128'h0 for addresses 11..15.
REQ-021 Slots SHALL hold their values until the next accepted `start` or reset. Reads during RUN return whatever is currently stored; they are meaningful only when `keys_valid` is 1.
REQ-022 `key_in` SHALL be sampled only at edge T; changes during RUN have no effect.

Reset
REQ-023 With `rst_n`=0 at a rising edge, the block SHALL enter IDLE and apply these reset values:
- `busy`=0, `done`=0, `keys_valid`=0;
- round counter 0, rcon 8'h01;
- all 11 slots 128'h0, so `rk_data`=0 at every address.
REQ-024 Reset in the middle of an operation SHALL abort expansion immediately with no `done` pulse. A `start` on the first edge after `rst_n` rises SHALL be accepted.

Structure
REQ-025 Shared package `aes_pkg` SHALL hold:
- `AES_NR`=10 and `AES_NK`=4;
- the 128-bit key type and 32-bit word type;
- the S-box function, `xtime` and `sub_word`/`rot_word` helpers.
REQ-026 One sub-module `aes_key_round` SHALL perform the purely combinational single-round expansion (prev key, rcon word -> next key), with four S-box instances. The FSM, counter, rcon register and 11x128 slot storage live in `aes_key_sched`.

Verification
REQ-027 FIPS-197 key test: `key_in`=2b7e151628aed2a6abf7158809cf4f3c with a 1-cycle `start`.
- `done` SHALL occur 10 cycles after the accept edge.
- slot1 = a0fafe1788542cb123a339392a6c7605.
- slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-028 All-zero key test: `key_in`=0.
- slot1 = 62636363626363636263636362636363.
- slot10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 Busy-ignore test: pulse `start` with a different key at cycles T+3 and T+10 (FIN). The results SHALL be identical to REQ-027 and exactly one `done` pulse SHALL occur.
REQ-030 Reset mid-run test: drop `rst_n` at T+5. After reset, all outputs SHALL be 0, there is no `done` pulse, and `rk_data` is 0 at addresses 0..10.
REQ-031 Out-of-range read test: with `keys_valid`=1, `rk_addr`=11 and `rk_addr`=15 SHALL both give `rk_data`=0.
REQ-032 Restart test: run REQ-027, then restart with the zero key. `keys_valid` SHALL drop at the accept edge, and the REQ-028 values SHALL appear at `done`.
